// File: rtl/mac_x2_sequencer.sv
// mac_x2_sequencer
// Operand-side sequencer for the two-lane 8-bit MAC hard block. Accepts a
// beat-count command, streams paired operands into the MAC through registers,
// follows the MAC pipeline with a tag shift register, accumulates the tagged
// results into a 32-bit sum and returns it on a valid/ready result port.
module mac_x2_sequencer #(
   parameter int unsigned MAC_LATENCY = 2,
   parameter int unsigned LEN_WIDTH   = 8
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [LEN_WIDTH-1:0] cmd_len,
   input  logic                 op_valid,
   output logic                 op_ready,
   input  logic [15:0]          op_a,
   input  logic [15:0]          op_b,
   output logic [7:0]           mac_dataa_0,
   output logic [7:0]           mac_dataa_1,
   output logic [7:0]           mac_datab_0,
   output logic [7:0]           mac_datab_1,
   input  logic [31:0]          mac_result,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [31:0]          res_data
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FEED,
      ST_DRAIN,
      ST_OUT
   } state_e;

   state_e               state_q, state_d;
   logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
   logic [31:0]          acc_q, acc_d;
   logic [MAC_LATENCY:0] tag_q;
   logic [15:0]          opa_q, opb_q;
   logic                 cmd_ready_q, op_ready_q, res_valid_q;
   logic [31:0]          res_data_q;

   logic cmd_fire, op_fire, res_fire, last_tag;

   // Handshake decode and next-state / accumulator computation.
   always_comb begin
      cmd_fire    = cmd_ready_q & cmd_valid;
      op_fire     = op_ready_q & op_valid;
      res_fire    = res_valid_q & res_ready;
      // The last tagged beat is at the pipe output when no younger tag remains.
      last_tag    = tag_q[MAC_LATENCY] && (tag_q[MAC_LATENCY-1:0] == '0);
      state_d     = state_q;
      remaining_d = remaining_q;
      acc_d       = acc_q;
      if (tag_q[MAC_LATENCY]) begin
         acc_d = acc_q + mac_result;
      end
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_fire) begin
               remaining_d = cmd_len;
               acc_d       = '0;
               state_d     = (cmd_len == '0) ? ST_OUT : ST_FEED;
            end
         end
         ST_FEED: begin
            if (op_fire) begin
               remaining_d = remaining_q - LEN_WIDTH'(1);
               if (remaining_q == LEN_WIDTH'(1)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (last_tag) begin
               state_d = ST_OUT;
            end
         end
         ST_OUT: begin
            if (res_fire) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, operand registers, tag pipe and registered handshake outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         acc_q       <= '0;
         tag_q       <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         cmd_ready_q <= 1'b0;
         op_ready_q  <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         acc_q       <= acc_d;
         tag_q       <= {tag_q[MAC_LATENCY-1:0], op_fire};
         opa_q       <= op_fire ? op_a : '0;
         opb_q       <= op_fire ? op_b : '0;
         cmd_ready_q <= (state_d == ST_IDLE);
         op_ready_q  <= (state_d == ST_FEED);
         res_valid_q <= (state_d == ST_OUT);
         // Capture the final sum (including the last accumulation) on entry to OUT.
         if ((state_q != ST_OUT) && (state_d == ST_OUT)) begin
            res_data_q <= acc_d;
         end
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign op_ready    = op_ready_q;
   assign res_valid   = res_valid_q;
   assign res_data    = res_data_q;
   assign mac_dataa_0 = opa_q[7:0];
   assign mac_dataa_1 = opa_q[15:8];
   assign mac_datab_0 = opb_q[7:0];
   assign mac_datab_1 = opb_q[15:8];

endmodule

// File: tb/tb_mac_x2_sequencer.sv
// Testbench for mac_x2_sequencer: behavioural MAC pipe plus a dot-product
// reference computed directly from the operand beats sent.
module tb_mac_x2_sequencer;
   localparam int unsigned LAT = 2;
   localparam int unsigned LW  = 8;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [LW-1:0] cmd_len = '0;
   logic          op_valid = 1'b0;
   logic          op_ready;
   logic [15:0]   op_a = '0;
   logic [15:0]   op_b = '0;
   logic [7:0]    mac_dataa_0, mac_dataa_1, mac_datab_0, mac_datab_1;
   logic [31:0]   mac_result;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [31:0]   res_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [15:0] A [256];
   logic [15:0] B [256];
   int          G [256];

   logic [31:0] pipe [LAT];

   mac_x2_sequencer #(.MAC_LATENCY(LAT), .LEN_WIDTH(LW)) dut (
      .clk(clk), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
      .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
      .mac_dataa_0(mac_dataa_0), .mac_dataa_1(mac_dataa_1),
      .mac_datab_0(mac_datab_0), .mac_datab_1(mac_datab_1),
      .mac_result(mac_result),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int dot(input logic [15:0] a, input logic [15:0] b);
      byte sa0, sa1, sb0, sb1;
      sa0 = a[7:0];  sa1 = a[15:8];
      sb0 = b[7:0];  sb1 = b[15:8];
      return int'(sa0) * int'(sb0) + int'(sa1) * int'(sb1);
   endfunction

   // MAC hard-block model: not reset, so stale products survive a sequencer reset.
   initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
   always @(posedge clk) begin
      pipe[0] <= 32'(dot({mac_dataa_1, mac_dataa_0}, {mac_datab_1, mac_datab_0}));
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign mac_result = pipe[LAT-1];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   // Issue a command at the current negedge; returns the cycle of the handshake.
   task automatic send_cmd(input int len, output int hc);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_len   = LW'(len);
      while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
      end
      hc = cyc;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_len   = LW'($urandom);
   endtask

   // Full command using beats A/B with gaps G; checks operands, latency and result.
   task automatic run_cmd(input string name, input int len, input int hold);
      int hc, h, n, exp_cyc;
      logic [31:0] expv;
      expv = '0;
      send_cmd(len, hc);
      h = hc;
      for (int i = 0; i < len; i++) begin
         op_valid = 1'b1; op_a = A[i]; op_b = B[i];
         checks++;
         if (op_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s op_ready beat %0d: got %b, required 1", name, i, op_ready);
         end
         n = 0;
         while (!op_ready && n < 100) begin @(negedge clk); n++; end
         h = cyc;
         expv += 32'(dot(A[i], B[i]));
         @(negedge clk);
         if (G[i] > 0 || i == len - 1) begin
            op_valid = 1'b0; op_a = 16'($urandom); op_b = 16'($urandom);
         end
         checks++;
         if ({mac_dataa_1, mac_dataa_0, mac_datab_1, mac_datab_0} !== {A[i], B[i]}) begin
            errors++;
            $display("FAIL %s mac_data beat %0d: got %h, required %h", name, i,
                     {mac_dataa_1, mac_dataa_0, mac_datab_1, mac_datab_0}, {A[i], B[i]});
         end
         for (int g = 0; g < G[i]; g++) begin
            @(negedge clk);
            checks++;
            if ({mac_dataa_1, mac_dataa_0, mac_datab_1, mac_datab_0} !== 32'h0) begin
               errors++;
               $display("FAIL %s mac_data gap after beat %0d: got %h, required 0", name, i,
                        {mac_dataa_1, mac_dataa_0, mac_datab_1, mac_datab_0});
            end
         end
      end
      exp_cyc = (len == 0) ? hc + 1 : h + 2 + int'(LAT);
      n = 0;
      while (!res_valid && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (res_valid !== 1'b1 || cyc != exp_cyc) begin
         errors++;
         $display("FAIL %s latency: res_valid=%b at cycle %0d, required 1 at cycle %0d",
                  name, res_valid, cyc, exp_cyc);
      end
      checks++;
      if (res_data !== expv) begin
         errors++;
         $display("FAIL %s res_data: got %h, required %h", name, res_data, expv);
      end
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         checks++;
         if ({res_valid, cmd_ready, op_ready, res_data} !== {3'b100, expv}) begin
            errors++;
            $display("FAIL %s hold %0d: valid/cmd_rdy/op_rdy/data=%b%b%b/%h, required 100/%h",
                     name, k, res_valid, cmd_ready, op_ready, res_data, expv);
         end
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      checks++;
      if ({res_valid, cmd_ready, op_ready} !== 3'b010) begin
         errors++;
         $display("FAIL %s release: valid/cmd_rdy/op_rdy=%b%b%b, required 010",
                  name, res_valid, cmd_ready, op_ready);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if ({cmd_ready, op_ready, res_valid, res_data,
              mac_dataa_1, mac_dataa_0, mac_datab_1, mac_datab_0} !== '0) begin
            errors++;
            $display("FAIL reset_low %0d: cmd/op/res=%b%b%b data=%h mac=%h, required all 0", k,
                     cmd_ready, op_ready, res_valid, res_data,
                     {mac_dataa_1, mac_dataa_0, mac_datab_1, mac_datab_0});
         end
      end
      resetn = 1'b1;
      @(negedge clk);
      checks++;
      if ({cmd_ready, op_ready, res_valid} !== 3'b100) begin
         errors++;
         $display("FAIL reset_release: cmd/op/res=%b%b%b, required 100",
                  cmd_ready, op_ready, res_valid);
      end
   endtask

   task automatic test_single();
      A[0] = 16'h0101; B[0] = 16'h0101; G[0] = 0;
      run_cmd("single_pos", 1, 0);
      A[0] = 16'h0101; B[0] = 16'hFFFF; G[0] = 0;
      run_cmd("single_neg", 1, 0);
   endtask

   task automatic test_gaps();
      for (int i = 0; i < 3; i++) begin
         A[i] = 16'h7F80; B[i] = 16'h7F80; G[i] = (i == 2) ? 0 : 2;
      end
      run_cmd("gaps", 3, 0);
   endtask

   task automatic test_zero_len();
      run_cmd("zero_len", 0, 5);
   endtask

   task automatic test_reset_mid_feed();
      int hc;
      send_cmd(4, hc);
      op_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
         op_a = 16'($urandom); op_b = 16'($urandom);
         @(negedge clk);
      end
      op_valid = 1'b0;
      resetn = 1'b0;
      #1;
      checks++;
      if ({cmd_ready, op_ready, res_valid, res_data,
           mac_dataa_1, mac_dataa_0, mac_datab_1, mac_datab_0} !== '0) begin
         errors++;
         $display("FAIL mid_feed_reset: cmd/op/res=%b%b%b data=%h mac=%h, required all 0",
                  cmd_ready, op_ready, res_valid, res_data,
                  {mac_dataa_1, mac_dataa_0, mac_datab_1, mac_datab_0});
      end
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      A[0] = 16'h0102; B[0] = 16'h0102; G[0] = 0;
      run_cmd("after_reset", 1, 0);
   endtask

   task automatic test_random();
      int len;
      for (int t = 0; t < 10; t++) begin
         len = $urandom_range(0, 12);
         for (int i = 0; i < len; i++) begin
            A[i] = 16'($urandom); B[i] = 16'($urandom);
            G[i] = (i == len - 1) ? 0 : $urandom_range(0, 2);
         end
         run_cmd("random", len, $urandom_range(0, 3));
      end
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 2; t++) begin
         for (int i = 0; i < 16; i++) begin
            A[i] = (t == 0) ? 16'h8080 : 16'($urandom);
            B[i] = (t == 0) ? 16'h8080 : 16'($urandom);
            G[i] = 0;
         end
         run_cmd("back_to_back", 16, 0);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_gaps();
      test_zero_len();
      test_reset_mid_feed();
      test_random();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
